// File: rtl/synapse_decoder.sv
// Per-slot decaying synaptic traces fed by spike events, scanned round-robin into an 8-bit current.
// One slot per enabled cycle, result registered (valid the cycle after the scan edge); no backpressure.
module synapse_decoder #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int DECAY_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ev_valid,
  input  logic [SLOT_W-1:0] ev_slot,
  input  logic [7:0]        ev_weight,
  output logic              cur_valid,
  output logic [SLOT_W-1:0] cur_slot,
  output logic [7:0]        cur_out
);

  logic [SLOT_W-1:0] scan_idx_q, scan_idx_d;
  logic [7:0]        pending_q [NUM_SLOTS];
  logic [7:0]        pending_d [NUM_SLOTS];
  logic [7:0]        trace_q   [NUM_SLOTS];
  logic [7:0]        trace_d   [NUM_SLOTS];
  logic              cur_valid_q, cur_valid_d;
  logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
  logic [7:0]        cur_out_q, cur_out_d;

  logic [NUM_SLOTS-1:0] ev_hit;
  logic [8:0]           ev_sum    [NUM_SLOTS];
  logic [7:0]           ev_acc    [NUM_SLOTS];
  logic [7:0]           add       [NUM_SLOTS];
  logic [7:0]           decayed   [NUM_SLOTS];
  logic [8:0]           trace_sum [NUM_SLOTS];
  logic [7:0]           trace_new [NUM_SLOTS];

  // Out-of-range slot indices match no slot, so such events vanish here.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign ev_hit[i]    = ev_valid && (ev_slot == SLOT_W'(i));
    assign ev_sum[i]    = {1'b0, pending_q[i]} + {1'b0, ev_weight};
    assign ev_acc[i]    = ev_sum[i][8] ? 8'hFF : ev_sum[i][7:0];
    assign add[i]       = ev_hit[i] ? ev_acc[i] : pending_q[i];
    assign decayed[i]   = trace_q[i] - (trace_q[i] >> DECAY_SHIFT);
    assign trace_sum[i] = {1'b0, decayed[i]} + {1'b0, add[i]};
    assign trace_new[i] = trace_sum[i][8] ? 8'hFF : trace_sum[i][7:0];
  end

  always_comb begin
    scan_idx_d  = scan_idx_q;
    cur_valid_d = 1'b0;
    cur_slot_d  = cur_slot_q;
    cur_out_d   = cur_out_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pending_d[i] = ev_hit[i] ? ev_acc[i] : pending_q[i];
      trace_d[i]   = trace_q[i];
      // A same-cycle event for the scanned slot is folded into add[], not left pending.
      if (en && (scan_idx_q == SLOT_W'(i))) begin
        pending_d[i] = 8'd0;
        trace_d[i]   = trace_new[i];
        cur_valid_d  = 1'b1;
        cur_slot_d   = scan_idx_q;
        cur_out_d    = trace_new[i];
      end
    end
    if (en) begin
      scan_idx_d = (scan_idx_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : scan_idx_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_q  <= '0;
      cur_valid_q <= 1'b0;
      cur_slot_q  <= '0;
      cur_out_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pending_q[i] <= '0;
        trace_q[i]   <= '0;
      end
    end else begin
      scan_idx_q  <= scan_idx_d;
      cur_valid_q <= cur_valid_d;
      cur_slot_q  <= cur_slot_d;
      cur_out_q   <= cur_out_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pending_q[i] <= pending_d[i];
        trace_q[i]   <= trace_d[i];
      end
    end
  end

  assign cur_valid = cur_valid_q;
  assign cur_slot  = cur_slot_q;
  assign cur_out   = cur_out_q;

endmodule

// File: tb/tb_synapse_decoder.sv
// Bench for synapse_decoder: scoreboard of expected scan results plus hand-derived spot values.
module tb_synapse_decoder;
  localparam int NS = 4;
  localparam int DS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_slot = 2'd0;
  logic [7:0] ev_weight = 8'd0;
  logic       cur_valid;
  logic [1:0] cur_slot;
  logic [7:0] cur_out;
  logic       c3_valid;
  logic [1:0] c3_slot;
  logic [7:0] c3_out;

  always #5 clk = ~clk;

  synapse_decoder #(.NUM_SLOTS(4), .SLOT_W(2), .DECAY_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .ev_valid(ev_valid), .ev_slot(ev_slot),
    .ev_weight(ev_weight), .cur_valid(cur_valid), .cur_slot(cur_slot), .cur_out(cur_out)
  );

  synapse_decoder #(.NUM_SLOTS(3), .SLOT_W(2), .DECAY_SHIFT(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .ev_valid(ev_valid), .ev_slot(ev_slot),
    .ev_weight(ev_weight), .cur_valid(c3_valid), .cur_slot(c3_slot), .cur_out(c3_out)
  );

  typedef struct packed {
    logic       v;
    logic [1:0] s;
    logic [7:0] o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t m_last;
  int   m_pend[NS];
  int   m_tr[NS];
  int   m_idx;
  int   n_vec = 0;
  int   n_bad = 0;
  int   tbl[9] = '{100, 50, 25, 13, 7, 4, 2, 1, 1};

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 0;
      m_tr[i]   = 0;
    end
    m_idx  = 0;
    m_last = '0;
    sb.delete();
  endtask

  // Drive one cycle, predict the registered result, and pop it once the edge has passed.
  task automatic step(input logic en_i, input logic v_i, input int sl, input int w);
    int s, a, nt;
    @(negedge clk);
    en = en_i; ev_valid = v_i; ev_slot = sl[1:0]; ev_weight = w[7:0];
    s = m_idx;
    if (en_i) begin
      a  = sat(m_pend[s] + ((v_i && sl == s) ? w : 0));
      nt = sat(m_tr[s] - (m_tr[s] >> DS) + a);
      m_tr[s]   = nt;
      m_pend[s] = 0;
      m_last    = {1'b1, s[1:0], nt[7:0]};
      m_idx     = (s + 1) % NS;
    end else begin
      m_last.v = 1'b0;
    end
    if (v_i && sl < NS && !(en_i && sl == s)) m_pend[sl] = sat(m_pend[sl] + w);
    sb.push_back(m_last);
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; ev_valid = 1'b0;
    model_reset();
    step(1, 1, 1, 50);
    step(1, 1, 2, 80);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL reset_pre: got v%0b s%0d o%0d want v%0b s%0d o%0d", cur_valid, cur_slot, cur_out, e.v, e.s, e.o);
      end
    end
    @(posedge clk);
    #3 rst = 1'b1;
    ev_valid = 1'b1; ev_slot = 2'd1; ev_weight = 8'd99;
    #1;
    n_vec++;
    if (cur_valid !== 1'b0 || cur_slot !== 2'd0 || cur_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_async: got v%0b s%0d o%0d want all 0", cur_valid, cur_slot, cur_out);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (cur_valid !== 1'b0 || cur_out !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got v%0b o%0d want 0 0", cur_valid, cur_out);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; ev_valid = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (cur_valid !== 1'b1 || cur_slot !== 2'(c % 4) || cur_out !== 8'd0 ||
          cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL idle_scan[%0d]: got v%0b s%0d o%0d want v1 s%0d o0", c, cur_valid, cur_slot, cur_out, c % 4);
      end
    end
  endtask

  task automatic test_single_event();
    int k = 0;
    step(1, 1, 2, 100);
    for (int c = 0; c < 45 && k < 9; c++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL single_model: got v%0b s%0d o%0d want v%0b s%0d o%0d", cur_valid, cur_slot, cur_out, e.v, e.s, e.o);
      end
      if (cur_valid === 1'b1 && cur_slot === 2'd2) begin
        n_vec++;
        if (cur_out !== 8'(tbl[k])) begin
          n_bad++;
          $display("FAIL single_decay[%0d]: got %0d want %0d", k, cur_out, tbl[k]);
        end
        k++;
      end else if (cur_out !== 8'd0) begin
        n_vec++; n_bad++;
        $display("FAIL single_other: slot %0d got %0d want 0", cur_slot, cur_out);
      end
    end
    n_vec++;
    if (k != 9) begin
      n_bad++;
      $display("FAIL single_visits: got %0d want 9", k);
    end
  endtask

  task automatic test_pending_sat();
    int k = 0;
    int want[2] = '{255, 128};
    step(0, 1, 1, 200);
    step(0, 1, 1, 100);
    n_vec++;
    if (cur_valid !== 1'b0 || cur_slot !== e.s || cur_out !== e.o) begin
      n_bad++;
      $display("FAIL psat_gated: got v%0b s%0d o%0d want v0 s%0d o%0d", cur_valid, cur_slot, cur_out, e.s, e.o);
    end
    for (int c = 0; c < 12 && k < 2; c++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL psat_model: got s%0d o%0d want s%0d o%0d", cur_slot, cur_out, e.s, e.o);
      end
      if (cur_valid === 1'b1 && cur_slot === 2'd1) begin
        n_vec++;
        if (cur_out !== 8'(want[k])) begin
          n_bad++;
          $display("FAIL psat_visit[%0d]: got %0d want %0d", k, cur_out, want[k]);
        end
        k++;
      end
    end
    n_vec++;
    if (k != 2) begin
      n_bad++;
      $display("FAIL psat_visits: got %0d want 2", k);
    end
  endtask

  task automatic test_trace_sat();
    int want[2] = '{200, 255};
    for (int r = 0; r < 2; r++) begin
      int k = 0;
      step(0, 1, 0, 200);
      for (int c = 0; c < 6 && k < 1; c++) begin
        step(1, 0, 0, 0);
        n_vec++;
        if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
          n_bad++;
          $display("FAIL tsat_model: got s%0d o%0d want s%0d o%0d", cur_slot, cur_out, e.s, e.o);
        end
        if (cur_valid === 1'b1 && cur_slot === 2'd0) begin
          n_vec++;
          if (cur_out !== 8'(want[r])) begin
            n_bad++;
            $display("FAIL tsat_visit[%0d]: got %0d want %0d", r, cur_out, want[r]);
          end
          k++;
        end
      end
      n_vec++;
      if (k != 1) begin
        n_bad++;
        $display("FAIL tsat_visits[%0d]: got %0d want 1", r, k);
      end
    end
  endtask

  task automatic test_collision();
    int k = 0;
    for (int c = 0; c < 4 && m_idx != 3; c++) step(1, 0, 0, 0);
    step(1, 1, 3, 40);
    n_vec++;
    if (cur_valid !== 1'b1 || cur_slot !== 2'd3 || cur_out !== 8'd40) begin
      n_bad++;
      $display("FAIL collide_hit: got v%0b s%0d o%0d want v1 s3 o40", cur_valid, cur_slot, cur_out);
    end
    for (int c = 0; c < 6 && k < 1; c++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL collide_model: got s%0d o%0d want s%0d o%0d", cur_slot, cur_out, e.s, e.o);
      end
      if (cur_valid === 1'b1 && cur_slot === 2'd3) begin
        n_vec++;
        if (cur_out !== 8'd20) begin
          n_bad++;
          $display("FAIL collide_next: got %0d want 20", cur_out);
        end
        k++;
      end
    end
    n_vec++;
    if (k != 1) begin
      n_bad++;
      $display("FAIL collide_visits: got %0d want 1", k);
    end
  endtask

  task automatic test_enable_gating();
    int frozen = m_idx;
    int sl[5] = '{0, 2, 0, 1, 2};
    int vv[5] = '{1, 1, 1, 0, 1};
    for (int c = 0; c < 5; c++) begin
      step(0, vv[c][0], sl[c], 30 + 10 * c);
      n_vec++;
      if (cur_valid !== 1'b0 || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL gate_off[%0d]: got v%0b s%0d o%0d want v0 s%0d o%0d", c, cur_valid, cur_slot, cur_out, e.s, e.o);
      end
    end
    step(1, 0, 0, 0);
    n_vec++;
    if (cur_valid !== 1'b1 || cur_slot !== 2'(frozen) || cur_out !== e.o) begin
      n_bad++;
      $display("FAIL gate_resume: got v%0b s%0d o%0d want v1 s%0d o%0d", cur_valid, cur_slot, cur_out, frozen, e.o);
    end
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0, 0);
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL gate_apply: got s%0d o%0d want s%0d o%0d", cur_slot, cur_out, e.s, e.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 80; c++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v%0b s%0d o%0d want v%0b s%0d o%0d", c, cur_valid, cur_slot, cur_out, e.v, e.s, e.o);
      end
    end
  endtask

  task automatic test_out_of_range();
    int idx3 = 0;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; ev_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 9; c++) begin
      step(1, 1, 3, 200);
      n_vec++;
      if (c3_valid !== 1'b1 || c3_slot !== 2'(idx3) || c3_out !== 8'd0) begin
        n_bad++;
        $display("FAIL oor_slot3[%0d]: got v%0b s%0d o%0d want v1 s%0d o0", c, c3_valid, c3_slot, c3_out, idx3);
      end
      idx3 = (idx3 + 1) % 3;
      n_vec++;
      if (cur_valid !== e.v || cur_slot !== e.s || cur_out !== e.o) begin
        n_bad++;
        $display("FAIL oor_ref4: got s%0d o%0d want s%0d o%0d", cur_slot, cur_out, e.s, e.o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_pending_sat();
    test_trace_sat();
    test_collision();
    test_enable_gating();
    test_back_to_back();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
